// File: rtl/alu_pkg.sv
// Shared aluc operation codes and FSM encoding for the execute-stage ALU.
// The ALU control decoder uses the same constants so both ends agree on the code map.
package alu_pkg;

    localparam int ALUC_W = 5;

    localparam logic [ALUC_W-1:0] ALU_ADD        = 5'd0;
    localparam logic [ALUC_W-1:0] ALU_ADDU       = 5'd1;
    localparam logic [ALUC_W-1:0] ALU_SUB        = 5'd2;
    localparam logic [ALUC_W-1:0] ALU_SUBU       = 5'd3;
    localparam logic [ALUC_W-1:0] ALU_AND        = 5'd4;
    localparam logic [ALUC_W-1:0] ALU_OR         = 5'd5;
    localparam logic [ALUC_W-1:0] ALU_XOR        = 5'd6;
    localparam logic [ALUC_W-1:0] ALU_NOR        = 5'd7;
    localparam logic [ALUC_W-1:0] ALU_SLT        = 5'd8;
    localparam logic [ALUC_W-1:0] ALU_SLTU       = 5'd9;
    localparam logic [ALUC_W-1:0] ALU_SLL        = 5'd10;
    localparam logic [ALUC_W-1:0] ALU_SRL        = 5'd11;
    localparam logic [ALUC_W-1:0] ALU_SRA        = 5'd12;
    localparam logic [ALUC_W-1:0] ALU_ROTL       = 5'd13;
    localparam logic [ALUC_W-1:0] ALU_LUI        = 5'd14;
    localparam logic [ALUC_W-1:0] ALU_LAST_LEGAL = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [ALUC_W-1:0] code);
        return (code >= ALU_SLL) && (code <= ALU_ROTL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational datapath: arithmetic, logic, compares and lui, plus the
// overflow and illegal-code flags. Shift codes produce zero here; alu_exec handles them.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [ALUC_W-1:0] aluc,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  result,
    output logic              overflow,
    output logic              illegal
);

    localparam int MSB  = WIDTH - 1;
    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (aluc)
            ALU_ADD: begin
                result   = sum;
                overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            ALU_ADDU: result = sum;
            ALU_SUB: begin
                result   = diff;
                overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            ALU_SUBU: result = diff;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROTL: result = '0;
            ALU_LUI:  result = {b[HALF-1:0], {HALF{1'b0}}};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: valid/ready wrapper around alu_core plus an iterative
// 1-bit-per-cycle shifter for sll/srl/sra/rotl. Results are registered and held until taken.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUC_W-1:0]  aluc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               overflow,
    output logic               zero,
    output logic               illegal
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_ONE = SW'(1);

    state_t            state_q, state_d;
    logic [ALUC_W-1:0] op_q;
    logic [WIDTH-1:0]  work_q, work_step;
    logic [SW-1:0]     cnt_q;
    logic [WIDTH-1:0]  result_q;
    logic              overflow_q, zero_q, illegal_q;

    logic [WIDTH-1:0]  core_result;
    logic              core_overflow, core_illegal;
    logic              accept;
    logic [SW-1:0]     shift_amt;
    state_t            accept_target;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .aluc     (aluc),
        .a        (a),
        .b        (b),
        .result   (core_result),
        .overflow (core_overflow),
        .illegal  (core_illegal)
    );

    assign accept        = in_valid && in_ready;
    assign shift_amt     = a[SW-1:0];
    assign accept_target = (is_shift_op(aluc) && (shift_amt != '0)) ? ST_SHIFT : ST_DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = accept_target;
            ST_SHIFT: if (cnt_q == CNT_ONE) state_d = ST_DONE;
            ST_DONE: begin
                if (accept)         state_d = accept_target;
                else if (out_ready) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // In DONE the consumer taking the result frees the slot in the same cycle.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
    end

    always_comb begin
        work_step = work_q;
        case (op_q)
            ALU_SLL:  work_step = {work_q[WIDTH-2:0], 1'b0};
            ALU_SRL:  work_step = {1'b0, work_q[WIDTH-1:1]};
            ALU_SRA:  work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            ALU_ROTL: work_step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            default:  work_step = work_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            op_q <= aluc;
            if (is_shift_op(aluc)) begin
                work_q <= b;
                cnt_q  <= shift_amt;
                // A zero shift amount finishes immediately with the unshifted operand.
                if (shift_amt == '0) begin
                    result_q   <= b;
                    overflow_q <= 1'b0;
                    zero_q     <= (b == '0);
                    illegal_q  <= 1'b0;
                end
            end else begin
                result_q   <= core_result;
                overflow_q <= core_overflow;
                zero_q     <= (core_result == '0);
                illegal_q  <= core_illegal;
            end
        end else if (state_q == ST_SHIFT) begin
            work_q <= work_step;
            cnt_q  <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                result_q   <= work_step;
                overflow_q <= 1'b0;
                zero_q     <= (work_step == '0);
                illegal_q  <= 1'b0;
            end
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, handshake sequences,
// reset abort, and randomized ops against an arithmetic reference model.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        zero;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    alu_exec #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluc      (aluc),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] res;
        logic        ovf;
        logic        zr;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic and whole-word shift operators.
    function automatic void ref_model(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                                      output logic [31:0] r, output logic o, output logic il, output int lat);
        longint s;
        int n;
        n   = int'(av[4:0]);
        r   = '0;
        o   = 1'b0;
        il  = 1'b0;
        lat = 1;
        case (op)
            5'd0: begin
                s = longint'($signed(av)) + longint'($signed(bv));
                r = av + bv;
                o = (s > SMAX) || (s < SMIN);
            end
            5'd1: r = av + bv;
            5'd2: begin
                s = longint'($signed(av)) - longint'($signed(bv));
                r = av - bv;
                o = (s > SMAX) || (s < SMIN);
            end
            5'd3: r = av - bv;
            5'd4: r = av & bv;
            5'd5: r = av | bv;
            5'd6: r = av ^ bv;
            5'd7: r = ~(av | bv);
            5'd8: r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            5'd9: r = (av < bv) ? 32'd1 : 32'd0;
            5'd10: begin r = bv << n; lat = n + 1; end
            5'd11: begin r = bv >> n; lat = n + 1; end
            5'd12: begin r = $signed(bv) >>> n; lat = n + 1; end
            5'd13: begin r = (n == 0) ? bv : ((bv << n) | (bv >> (32 - n))); lat = n + 1; end
            5'd14: r = {bv[15:0], 16'h0000};
            default: il = 1'b1;
        endcase
    endfunction

    // Issue one op, count cycles from the accept edge to out_valid, then retire it.
    task automatic run_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] r, output logic o, output logic z, output logic il,
                          output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        aluc     = op;
        a        = av;
        b        = bv;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r  = result;
        o  = overflow;
        z  = zero;
        il = illegal;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [31:0] got_r, exp_r;
    logic        got_o, got_z, got_il, exp_o, exp_il;
    int          got_lat, exp_lat;
    logic        seen_valid;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  b2b_op[3];
    logic [31:0] b2b_a[3];
    logic [31:0] b2b_b[3];
    logic [31:0] b2b_exp[3];

    initial begin
        vecs[0]  = '{"add_ovf",    5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1};
        vecs[1]  = '{"addu_noovf", 5'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{"sub_zero",   5'd2,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};
        vecs[3]  = '{"slt_neg",    5'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{"sltu_big",   5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};
        vecs[5]  = '{"sra_4",      5'd12, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b0, 5};
        vecs[6]  = '{"sll_0",      5'd10, 32'h00000000, 32'h00001234, 32'h00001234, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{"rotl_31",    5'd13, 32'h0000001F, 32'h80000001, 32'hC0000000, 1'b0, 1'b0, 1'b0, 32};
        vecs[8]  = '{"illegal_20", 5'd20, 32'h00001234, 32'h00005678, 32'h00000000, 1'b0, 1'b1, 1'b1, 1};
        vecs[9]  = '{"lui",        5'd14, 32'h00000000, 32'h0000ABCD, 32'hABCD0000, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{"sub_ovf",    5'd2,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1};
        vecs[11] = '{"nor_zero",   5'd7,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{"srl_8",      5'd11, 32'h00000008, 32'h0000FF00, 32'h000000FF, 1'b0, 1'b0, 1'b0, 9};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluc      = '0;
        a         = '0;
        b         = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    result,         32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_zero",      32'(zero),      32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Reset asserted mid-run while a result is held
        in_valid = 1'b1;
        aluc     = 5'd0;
        a        = 32'd1;
        b        = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid",  32'(out_valid), 32'd1);
        check("pre_rst_result", result,         32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result",    result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].av, vecs[i].bv, got_r, got_o, got_z, got_il, got_lat);
            check({vecs[i].name, "_result"},   got_r,         vecs[i].res);
            check({vecs[i].name, "_overflow"}, 32'(got_o),    32'(vecs[i].ovf));
            check({vecs[i].name, "_zero"},     32'(got_z),    32'(vecs[i].zr));
            check({vecs[i].name, "_illegal"},  32'(got_il),   32'(vecs[i].ill));
            check({vecs[i].name, "_latency"},  32'(got_lat),  32'(vecs[i].lat));
        end

        // Backpressure: xor result held, a new op is ignored until out_ready
        @(negedge clk);
        in_valid = 1'b1;
        aluc     = 5'd6;
        a        = 32'h0000F0F0;
        b        = 32'h0000FF00;
        @(negedge clk);
        aluc = 5'd4;
        a    = 32'h000000FF;
        b    = 32'h0000000F;
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result",    result,         32'h00000FF0);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_valid",  32'(out_valid), 32'd1);
        check("bp_next_result", result,         32'h0000000F);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Back-to-back stream: one result per cycle, order preserved
        b2b_op[0] = 5'd5;  b2b_a[0] = 32'h000000F0; b2b_b[0] = 32'h0000000F; b2b_exp[0] = 32'h000000FF;
        b2b_op[1] = 5'd4;  b2b_a[1] = 32'h000000F0; b2b_b[1] = 32'h0000003C; b2b_exp[1] = 32'h00000030;
        b2b_op[2] = 5'd14; b2b_a[2] = 32'h00000000; b2b_b[2] = 32'h0000ABCD; b2b_exp[2] = 32'hABCD0000;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        aluc      = b2b_op[0];
        a         = b2b_a[0];
        b         = b2b_b[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_valid",  32'(out_valid), 32'd1);
            check("b2b_result", result,         b2b_exp[i]);
            if (i < 2) begin
                aluc = b2b_op[i+1];
                a    = b2b_a[i+1];
                b    = b2b_b[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Abort a long sll with reset; no result must ever appear
        @(negedge clk);
        in_valid = 1'b1;
        aluc     = 5'd10;
        a        = 32'd20;
        b        = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result",    result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        seen_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", 32'(seen_valid), 32'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 5'($urandom_range(0, 16));
            ra  = $urandom;
            rb  = $urandom;
            ref_model(rop, ra, rb, exp_r, exp_o, exp_il, exp_lat);
            run_op(rop, ra, rb, got_r, got_o, got_z, got_il, got_lat);
            check("rand_result",   got_r,          exp_r);
            check("rand_overflow", 32'(got_o),     32'(exp_o));
            check("rand_zero",     32'(got_z),     32'(exp_r == 32'd0));
            check("rand_illegal",  32'(got_il),    32'(exp_il));
            check("rand_latency",  32'(got_lat),   32'(exp_lat));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU that consumes the 5-bit aluc code produced by the ALU control decoder, plus two operands.
- Returns a registered result over a valid/ready handshake.
- Logic/arithmetic ops complete in 1 cycle. Shifts and rotates run on an iterative 1-bit-per-cycle shifter, so latency depends on the shift amount.
- Sits between the register-read stage and writeback in the multi-cycle CPU.

Parameters:
- WIDTH, 32, datapath width. Must be a power of two and >= 16. The shift-count width SW = log2(WIDTH) is derived from it.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  op/operands presented.
- in_ready  out  1  block can accept an op this cycle.
- aluc  in  5  operation code (see Behaviour).
- a  in  WIDTH  operand A. Low SW bits are the shift amount for codes 10-13.
- b  in  WIDTH  operand B. This is the value shifted for codes 10-13.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  operation result.
- overflow  out  1  signed overflow; only codes 0 and 2 can set it.
- zero  out  1  result == 0.
- illegal  out  1  aluc was 15..31.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; result=0; overflow=0; zero=0; illegal=0; shift counter=0. in_ready=1 once rst_n=1.
- Accept condition: in_valid && in_ready at a rising edge. a, b and aluc are captured on that edge.
- Codes:
  - 0 add: a+b, overflow flagged.
  - 1 addu: a+b, no flag.
  - 2 sub: a-b, overflow flagged.
  - 3 subu: a-b, no flag.
  - 4 and. 5 or. 6 xor. 7 nor.
  - 8 slt: signed compare, result 1/0.
  - 9 sltu: unsigned compare, result 1/0.
  - 10 sll. 11 srl. 12 sra.
  - 13 rotate-left by a[SW-1:0].
  - 14 lui: {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 15-31: result=0, illegal=1.
- Arithmetic: all ops wrap modulo 2^WIDTH; the result is written even when overflow=1. Overflow = operand signs equal (add) or different (sub) AND result sign differs from a's sign.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, accept, code not in 10-13: compute in alu_core, register outputs, go to DONE. out_valid=1 on the next cycle (latency 1).
  - IDLE, accept, code in 10-13: load working reg = b and counter = a[SW-1:0].
    - If counter == 0, go to DONE with result = b (latency 1).
    - Otherwise go to SHIFT.
  - SHIFT: each cycle shift/rotate the working reg by 1 bit (sra replicates the MSB) and decrement counter. When counter reaches 1 on that step, go to DONE. Total latency n+1 cycles for shift amount n (max WIDTH).
  - DONE: out_valid=1. Outputs hold stable until out_ready=1.
    - On out_ready with no new accept: go to IDLE, out_valid=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back single-cycle ops at 1/cycle.
- Simultaneous out_ready and accept in DONE: the old result retires and the new op is captured on the same edge. The next state follows the IDLE-accept rules for the new op.
- in_valid while busy (SHIFT, or DONE without out_ready): ignored. The upstream must hold its inputs.
- Flag updates: overflow, zero and illegal update together with result, and only when a new result is registered.
- Reset mid-shift: the op is abandoned, state returns to IDLE, and no out_valid is produced.

Decomposition:
- Shared package alu_pkg:
  - aluc localparams (ALU_ADD=0 ... ALU_LUI=14).
  - ALU_LAST_LEGAL=14.
  - FSM state encoding (IDLE=0, SHIFT=1, DONE=2).
  - The ALU control decoder is to be retargeted to use the same constants.
- One sub-module, alu_core: purely combinational single-cycle datapath for codes 0-9 and 14, plus the overflow/illegal flags. alu_exec owns the FSM, the iterative shifter and the handshake.

Test Plan:
- Reset + add: rst_n low mid-run then high; aluc=0, a=0x7FFFFFFF, b=1 -> one cycle later out_valid=1, result=0x80000000, overflow=1, zero=0. Repeat with aluc=1 -> overflow=0.
- Sub/slt/sltu: aluc=2, a=5, b=5 -> result=0, zero=1. aluc=8, a=0xFFFFFFFF, b=1 -> result 1. aluc=9, same operands -> result 0.
- Shift latency:
  - aluc=12, a=4, b=0x80000000 -> out_valid exactly 5 cycles after accept, result=0xF8000000.
  - aluc=10, a=0, b=0x1234 -> latency 1, result=0x1234.
  - aluc=13, a=31, b=0x80000001 -> result=0xC0000000 after 32 cycles.
- Backpressure: hold out_ready=0 for 3 cycles after an xor result -> result stable, in_ready=0, a new in_valid is ignored. Release -> the pending op is accepted on the same edge.
- Back-to-back: in_valid and out_ready held high, stream and/or/lui(b=0xABCD -> 0xABCD0000) -> one result per cycle, order preserved.
- Illegal + abort: aluc=20 -> result=0, illegal=1. Start sll with a=20, pull rst_n low after 3 cycles -> out_valid never asserts, state IDLE, in_ready=1 after reset release.
